// File: rtl/ram_pkg.sv
// ram_pkg: access-type encodings, FSM states and access-size helper for ram_sync_bytemem
package ram_pkg;
  typedef enum logic [1:0] {
    TD_BYTE = 2'b00,
    TD_HALF = 2'b01,
    TD_WORD = 2'b10,
    TD_RSVD = 2'b11
  } td_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;
  // Bytes touched by an access; reserved type touches nothing.
  function automatic logic [2:0] td_size(td_e t);
    return t == TD_BYTE ? 3'd1 : t == TD_HALF ? 3'd2 : t == TD_WORD ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: 2**ADDR_W x 8 storage with four byte lanes at a..a+3 (lane 0 = MSB)
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [7:0] mem [2**ADDR_W];
  // Lane k reads mem[a+k]; out-of-range lanes are never used by the top level.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < 4; k++) rdata_o[31-8*k -: 8] = mem[addr_i + ADDR_W'(k)];
  end
  // Lane k writes mem[a+k] when enabled; contents are never reset.
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (we_i[k]) mem[addr_i + ADDR_W'(k)] <= wdata_i[31-8*k -: 8];
endmodule

// File: rtl/ram_sync_bytemem.sv
// ram_sync_bytemem: big-endian byte RAM behind a four-phase mov/moc handshake.
// Define RAM_ALIGN_CHECK_EN to reject unaligned halfword/word accesses.
module ram_sync_bytemem
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  type_data,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          rw_q, sext_q, moc_q, err_q;
  td_e           td_q;
  logic [31:0]   addr_q, din_q, dout_q;
  logic          last, bad;
  logic [3:0]    we;
  logic [31:0]   wdata, rdata, dout_d;
  ram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk    (clk),
    .addr_i (addr_q[ADDR_W-1:0]),
    .we_i   (we),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );
  // Request checks, write lane enables and extended read data from latched request.
  always_comb begin
    last = cnt_q == CW'(WAIT_CYCLES - 1);
`ifdef RAM_ALIGN_CHECK_EN
    bad = td_q == TD_RSVD || ({1'b0, addr_q} + {30'b0, td_size(td_q)}) > 33'(DEPTH)
       || (td_q == TD_HALF && addr_q[0]) || (td_q == TD_WORD && addr_q[1:0] != 2'b00);
`else
    bad = td_q == TD_RSVD || ({1'b0, addr_q} + {30'b0, td_size(td_q)}) > 33'(DEPTH);
`endif
    we = (state_q == ST_ACCESS && last && !rw_q && !bad)
       ? (td_q == TD_BYTE ? 4'b0001 : td_q == TD_HALF ? 4'b0011 : 4'b1111) : 4'b0000;
    wdata = td_q == TD_BYTE ? {din_q[7:0], 24'b0} : td_q == TD_HALF ? {din_q[15:0], 16'b0} : din_q;
    dout_d = td_q == TD_BYTE ? {{24{sext_q & rdata[31]}}, rdata[31:24]}
           : td_q == TD_HALF ? {{16{sext_q & rdata[31]}}, rdata[31:16]} : rdata;
  end
  // Handshake FSM: latch in IDLE, wait then execute in ACCESS, hold result in DONE until mov drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      sext_q  <= 1'b0;
      td_q    <= TD_BYTE;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (mov) begin
          rw_q    <= rw;
          sext_q  <= sign_ext;
          td_q    <= td_e'(type_data);
          addr_q  <= address;
          din_q   <= data_in;
          cnt_q   <= '0;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: if (last) begin
          state_q <= ST_DONE;
          moc_q   <= 1'b1;
          err_q   <= bad;
          if (rw_q && !bad) dout_q <= dout_d;
        end else cnt_q <= cnt_q + 1'b1;
        ST_DONE: if (!mov) begin
          state_q <= ST_IDLE;
          moc_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign data_out = dout_q;
  assign moc      = moc_q;
  assign err      = err_q;
endmodule

// File: tb/tb_ram_sync_bytemem.sv
// tb_ram_sync_bytemem: directed requests with a scoreboard queue checked by a moc-edge monitor
module tb_ram_sync_bytemem;
  localparam int WAIT = 3;
  logic        clk = 1'b0;
  logic        rst_n, mov, rw, sign_ext;
  logic [1:0]  type_data;
  logic [31:0] address, data_in, data_out;
  logic        moc, err;
  logic        moc_prev = 1'b0;
  logic [32:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  ram_sync_bytemem #(.ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .mov(mov), .rw(rw), .type_data(type_data),
    .sign_ext(sign_ext), .address(address), .data_in(data_in),
    .data_out(data_out), .moc(moc), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endfunction

  // Monitor: each rising moc must match the oldest queued expectation.
  always @(negedge clk) begin
    if (moc && !moc_prev) begin
      if (exp_q.size() == 0) chk(1'b0, "unexpected_moc", 32'(moc), 32'd0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk(err === e[32], "err", 32'(err), 32'(e[32]));
        chk(data_out === e[31:0], "data_out", data_out, e[31:0]);
      end
    end
    moc_prev = moc;
  end

  task automatic req(input logic r, input logic [1:0] td, input logic sx, input logic [31:0] a,
                     input logic [31:0] d, input logic e_err, input logic [31:0] e_out, input int hold);
    int edges;
    exp_q.push_back({e_err, e_out});
    @(posedge clk); #2;
    rw = r; type_data = td; sign_ext = sx; address = a; data_in = d; mov = 1'b1;
    edges = 0;
    while (!moc && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        rw = ~r; type_data = ~td; sign_ext = ~sx; address = 32'h55; data_in = 32'h12345678;
      end
    end
    // edges counts the sampling edge as the first one
    chk(edges == WAIT + 1, "latency", 32'(edges), 32'(WAIT + 1));
    if (!moc) void'(exp_q.pop_back());
    repeat (hold) begin
      @(posedge clk); #1;
      chk(moc === 1'b1, "moc_hold", 32'(moc), 32'd1);
    end
    mov = 1'b0;
    edges = 0;
    while (moc && edges < 5) begin
      @(posedge clk); #1;
      edges++;
    end
    chk(moc === 1'b0 && err === 1'b0, "moc_err_clear", {30'd0, moc, err}, 32'd0);
  endtask

  initial begin
    logic [32:0] half11;
`ifdef RAM_ALIGN_CHECK_EN
    half11 = {1'b1, 32'hFFFFFFAA};
`else
    half11 = {1'b0, 32'h0000ADBE};
`endif
    rst_n = 1'b0; mov = 1'b0; rw = 1'b0; type_data = 2'b00; sign_ext = 1'b0;
    address = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(moc === 1'b0, "reset_moc", 32'(moc), 32'd0);
    chk(err === 1'b0, "reset_err", 32'(err), 32'd0);
    chk(data_out === 32'd0, "reset_data_out", data_out, 32'd0);
    #1 rst_n = 1'b1;
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 0);
    req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000000DE, 0);
    req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h000000AD, 0);
    req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'h000000BE, 0);
    req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h000000EF, 0);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 0);
    req(1'b0, 2'b00, 1'b0, 32'h20, 32'h80, 1'b0, 32'hDEADBEEF, 0);
    req(1'b1, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, 32'hFFFFFF80, 0);
    req(1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00000080, 0);
    req(1'b0, 2'b01, 1'b0, 32'h30, 32'h8001, 1'b0, 32'h00000080, 0);
    req(1'b1, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 32'hFFFF8001, 0);
    req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h11223344, 1'b0, 32'hFFFF8001, 0);
    req(1'b0, 2'b10, 1'b0, 32'hFE, 32'hCAFEBABE, 1'b1, 32'hFFFF8001, 0);
    req(1'b1, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h11223344, 0);
    req(1'b1, 2'b01, 1'b0, 32'hFE, 32'h0, 1'b0, 32'h00003344, 0);
    req(1'b0, 2'b00, 1'b0, 32'hFF, 32'hAA, 1'b0, 32'h00003344, 0);
    req(1'b1, 2'b00, 1'b1, 32'hFF, 32'h0, 1'b0, 32'hFFFFFFAA, 0);
    req(1'b1, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFFFFAA, 0);
    req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0, half11[32], half11[31:0], 0);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 5);
    req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 0);
    // Reset in the middle of a byte write to 0x10: nothing may be stored.
    @(posedge clk); #2;
    rw = 1'b0; type_data = 2'b00; sign_ext = 1'b0; address = 32'h10; data_in = 32'h55; mov = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk(moc === 1'b0, "rst_access_moc", 32'(moc), 32'd0);
    chk(err === 1'b0, "rst_access_err", 32'(err), 32'd0);
    chk(data_out === 32'd0, "rst_access_data_out", data_out, 32'd0);
    mov = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000000DE, 0);
    repeat (2) @(posedge clk);
    chk(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
